// File: rtl/servo_cmd_loader.sv
// servo_cmd_loader: decodes framed byte commands (HEADER, channel, duty) into a shared duty bus plus one-hot load strobes.
// Latency: dutycycle updates on the edge that accepts the last frame byte; load[ch] rises one edge later for LOAD_PULSE_CYCLES.
// Backpressure: rx_ready is low during APPLY/HOLD so the upstream holds its byte. `SERVO_CMD_CHECKSUM_EN adds a 4th byte (ch ^ duty).
module servo_cmd_loader #(
  parameter int         NUM_CHANNELS      = 8,
  parameter logic [7:0] HEADER            = 8'hFF,
  parameter int         LOAD_PULSE_CYCLES = 4,
  parameter int         TIMEOUT_CYCLES    = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [7:0]              dutycycle,
  output logic [NUM_CHANNELS-1:0] load,
  output logic                    busy,
  output logic                    frame_err,
  output logic [15:0]             cmd_count
);

  // Counter widths never collapse to zero bits, even for the minimum parameter values.
  localparam int TO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HOLD_W = (LOAD_PULSE_CYCLES > 2) ? $clog2(LOAD_PULSE_CYCLES) : 1;

  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOAD_PULSE_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHAN  = 3'd1;
  localparam logic [2:0] S_DUTY  = 3'd2;
  localparam logic [2:0] S_APPLY = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
`ifdef SERVO_CMD_CHECKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd5;
`endif

  logic [2:0]              state_q, state_d;
  logic [7:0]              chan_q, chan_d;
`ifdef SERVO_CMD_CHECKSUM_EN
  logic [7:0]              duty_q, duty_d;
`endif
  logic [7:0]              dutycycle_q, dutycycle_d;
  logic [NUM_CHANNELS-1:0] load_q, load_d;
  logic                    frame_err_q, frame_err_d;
  logic [15:0]             cmd_count_q, cmd_count_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;

  logic [NUM_CHANNELS-1:0] chan_onehot;
  logic                    accept;
  logic                    chan_ok;
  logic                    to_expired;

  // Byte transfer handshake and per-byte qualifiers.
  assign rx_ready   = (state_q != S_APPLY) && (state_q != S_HOLD);
  assign accept     = rx_valid && rx_ready;
  assign chan_ok    = ({24'd0, rx_data} < 32'(NUM_CHANNELS));
  assign to_expired = (to_cnt_q == TO_LAST);

  // Decode the stored channel index into the strobe pattern.
  always_comb begin
    chan_onehot = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      chan_onehot[i] = (chan_q == 8'(i));
    end
  end

  // Frame parser: next state, strobes, error pulse and the idle/hold counters.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
`ifdef SERVO_CMD_CHECKSUM_EN
    duty_d      = duty_q;
`endif
    dutycycle_d = dutycycle_q;
    load_d      = '0;
    frame_err_d = 1'b0;
    cmd_count_d = cmd_count_q;
    to_cnt_d    = '0;           // cleared in IDLE/APPLY/HOLD and on every accepted byte
    hold_cnt_d  = '0;

    case (state_q)
      S_IDLE: begin
        // Non-header bytes between frames are dropped silently.
        if (accept && (rx_data == HEADER)) begin
          state_d = S_CHAN;
        end
      end

      S_CHAN: begin
        if (accept) begin
          if (chan_ok) begin
            chan_d  = rx_data;
            state_d = S_DUTY;
          end else if (rx_data != HEADER) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
          // A repeated header keeps us here: the frame restarts.
        end else if (to_expired) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_DUTY: begin
        // Every byte value is a legal duty, including one equal to HEADER.
        if (accept) begin
`ifdef SERVO_CMD_CHECKSUM_EN
          duty_d  = rx_data;
          state_d = S_CHK;
`else
          dutycycle_d = rx_data;
          state_d     = S_APPLY;
`endif
        end else if (to_expired) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

`ifdef SERVO_CMD_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          if (rx_data == (chan_q ^ duty_q)) begin
            dutycycle_d = duty_q;
            state_d     = S_APPLY;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end else if (to_expired) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
`endif

      S_APPLY: begin
        // dutycycle already settled on entry; raise the strobe one cycle later.
        load_d  = chan_onehot;
        state_d = S_HOLD;
      end

      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          cmd_count_d = cmd_count_q + 16'd1;
          state_d     = S_IDLE;
        end else begin
          load_d     = chan_onehot;
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears load at once, even mid-pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      chan_q      <= '0;
`ifdef SERVO_CMD_CHECKSUM_EN
      duty_q      <= '0;
`endif
      dutycycle_q <= '0;
      load_q      <= '0;
      frame_err_q <= 1'b0;
      cmd_count_q <= '0;
      to_cnt_q    <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
`ifdef SERVO_CMD_CHECKSUM_EN
      duty_q      <= duty_d;
`endif
      dutycycle_q <= dutycycle_d;
      load_q      <= load_d;
      frame_err_q <= frame_err_d;
      cmd_count_q <= cmd_count_d;
      to_cnt_q    <= to_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign dutycycle = dutycycle_q;
  assign load      = load_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = frame_err_q;
  assign cmd_count = cmd_count_q;

endmodule

// File: doc/servo_cmd_loader.md
Name: servo_cmd_loader

Overview:
Byte-stream command decoder sitting directly upstream of the N servo PWM channels. Accepts framed commands (header, channel index, duty byte) over a valid/ready byte interface. Drives the shared 8-bit dutycycle bus and a one-hot per-channel load strobe, so each channel latches its new duty on the rising edge of its load bit. The duty value is guaranteed stable before, during and after that edge.

Parameters:
NUM_CHANNELS, 8, number of PWM channels served; width of load; valid channel indices 0..NUM_CHANNELS-1
HEADER, 8'hFF, frame start byte
LOAD_PULSE_CYCLES, 4, clk cycles load[ch] is held high (min 1)
TIMEOUT_CYCLES, 1000000, max idle clk cycles between bytes inside a frame before abort (min 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
rx_data  input  8  incoming command byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader can accept a byte; transfer occurs when rx_valid && rx_ready at a clk edge
dutycycle  output  8  shared duty bus to all PWM channels (registered)
load  output  NUM_CHANNELS  one-hot latch strobes, bit i feeds channel i load (registered)
busy  output  1  high whenever state is not IDLE
frame_err  output  1  one-cycle pulse on any aborted frame
cmd_count  output  16  count of applied frames, wraps 16'hFFFF -> 0

Behaviour:
- Reset values: state IDLE, dutycycle 0, load 0, frame_err 0, cmd_count 0, busy 0, rx_ready 1. Reset during HOLD drops load to 0 immediately (async); a partial frame is discarded.
- rx_ready = 1 in IDLE, CHAN, DUTY (and CHK); 0 in APPLY and HOLD. Bytes presented while rx_ready=0 are not consumed; the upstream holds them.
- IDLE: accepted byte == HEADER -> CHAN. Any other byte is silently discarded with no error.
- CHAN: byte < NUM_CHANNELS -> store index -> DUTY. Byte == HEADER -> stay in CHAN (resync, no error). Else frame_err pulse -> IDLE.
- DUTY: store any value 0x00..0xFF (0xFF is legal here, not a header) -> APPLY (or CHK with the feature).
- APPLY (1 cycle): dutycycle register takes the stored duty on entry; load stays all-zero, giving one full cycle of setup before the strobe -> HOLD.
- HOLD: load[ch]=1, all other bits 0, for exactly LOAD_PULSE_CYCLES cycles; dutycycle unchanged. On exit: load -> 0, cmd_count +1, -> IDLE.
- Timing: duty byte accepted at edge E0; dutycycle shows the new value after E0; load[ch] is high after E1 until E1+LOAD_PULSE_CYCLES; rx_ready returns high at that same edge. Back-to-back frames are therefore one byte per cycle apart, plus APPLY/HOLD gaps.
- dutycycle holds its last applied value indefinitely, including across aborted frames.
- Timeout: in CHAN/DUTY/CHK, a counter increments each cycle without an accepted byte and clears on each accepted byte. Reaching TIMEOUT_CYCLES-1 -> frame_err pulse -> IDLE. Counter width is clog2(TIMEOUT_CYCLES); it is cleared in IDLE.
- frame_err and the state transition happen in the same edge; frame_err is registered and high for exactly 1 cycle.

Optional Feature:
SERVO_CMD_CHECKSUM_EN
- Defined: frame is 4 bytes; after DUTY go to CHK. The 4th byte must equal channel XOR duty. Match -> APPLY. Mismatch -> frame_err pulse, no load, dutycycle unchanged, -> IDLE. Timeout also applies in CHK.
- Undefined: 3-byte frame, no CHK state, DUTY -> APPLY directly.

Test Plan:
- Reset, then stream FF 03 7F -> dutycycle=0x7F one cycle before load[3] rises; load=8'b0000_1000 for 4 cycles; cmd_count=1; other load bits never set.
- Stream 12 FF FF 05 FF -> leading 0x12 ignored, double header resyncs; dutycycle=0xFF, load[5] pulses; frame_err never asserted.
- Stream FF 09 (NUM_CHANNELS=8) -> frame_err 1-cycle pulse, no load, dutycycle keeps previous 0xFF, next FF 00 10 applies normally.
- TIMEOUT_CYCLES=16: send FF 02, then idle 20 cycles -> frame_err pulses 16 cycles after 0x02 accepted, returns to IDLE; later 0x40 byte is ignored as non-header.
- Hold rx_valid high with continuous frames FF 01 20 FF 02 30 -> rx_ready low during APPLY+HOLD, no byte lost; load[1] then load[2] pulse, dutycycle 0x20 then 0x30.
- Assert reset mid-HOLD -> load=0 immediately, dutycycle=0, cmd_count=0; with SERVO_CMD_CHECKSUM_EN: FF 04 0F 0B applies, FF 04 0F 0C -> frame_err, no load.
